// File: rtl/run_length_detector.sv
// run_length_detector
//   Detects RUN_LEN consecutive matching samples on serial input x. The
//   matching level is chosen at run time by polarity (0: ones, 1: zeros).
//   All outputs are registered; state and run count are exposed for debug.
//   Optional hit counter enabled by defining RUN_HIT_COUNT_EN.
module run_length_detector #(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = $clog2(RUN_LEN + 1)
`ifdef RUN_HIT_COUNT_EN
  , parameter int HIT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             polarity,
  output logic             y,
  output logic             y_pulse,
  output logic [CNT_W-1:0] run_cnt,
  output logic [1:0]       state
`ifdef RUN_HIT_COUNT_EN
  , output logic [HIT_W-1:0] hit_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COUNT   = 2'b01,
    ST_DETECT  = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LP_RUN = CNT_W'(RUN_LEN);

  state_t           r_state;
  logic [CNT_W-1:0] r_run_cnt;
  logic             r_y;
  logic             r_y_pulse;
  logic             r_pol_q;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_pulse_nxt;
  logic             w_match;

  assign w_match   = x ^ polarity;
  assign w_cnt_inc = r_run_cnt + 1'b1;

  // Next-state and next-output logic; a polarity change overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_run_cnt;
    w_pulse_nxt = 1'b0;
    if (polarity != r_pol_q || r_state == ST_ILLEGAL) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (en) begin
      case (r_state)
        ST_IDLE: begin
          if (w_match) begin
            w_cnt_nxt = CNT_W'(1);
            if (RUN_LEN == 1) begin
              w_state_nxt = ST_DETECT;
              w_pulse_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_COUNT;
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end
        ST_COUNT: begin
          if (w_match) begin
            // run_cnt is below RUN_LEN here, so the increment cannot wrap
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == LP_RUN) begin
              w_state_nxt = ST_DETECT;
              w_pulse_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        ST_DETECT: begin
          if (w_match) begin
            w_cnt_nxt = LP_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, run count, registered flags and polarity history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_run_cnt <= '0;
      r_y       <= 1'b0;
      r_y_pulse <= 1'b0;
      r_pol_q   <= polarity;
    end else begin
      r_state   <= w_state_nxt;
      r_run_cnt <= w_cnt_nxt;
      r_y       <= (w_state_nxt == ST_DETECT);
      r_y_pulse <= w_pulse_nxt;
      r_pol_q   <= polarity;
    end
  end

  assign y       = r_y;
  assign y_pulse = r_y_pulse;
  assign run_cnt = r_run_cnt;
  assign state   = r_state;

`ifdef RUN_HIT_COUNT_EN
  logic [HIT_W-1:0] r_hit_cnt;

  // Count detections, saturating at all-ones; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt <= '0;
    end else if (r_y_pulse && r_hit_cnt != {HIT_W{1'b1}}) begin
      r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  assign hit_cnt = r_hit_cnt;
`else
  // No hit counter in this build.
`endif

endmodule

// File: tb/tb_run_length_detector.sv
// Testbench for run_length_detector: directed sequences plus randomized
// stimulus, checked against a run-length model through an expected queue.
module tb_run_length_detector;

  localparam int RUN_LEN = 3;
  localparam int CNT_W   = $clog2(RUN_LEN + 1);
`ifdef RUN_HIT_COUNT_EN
  localparam int HIT_W   = 8;
  localparam int W       = 4 + CNT_W + HIT_W;
`else
  localparam int W       = 4 + CNT_W;
`endif

  logic             clk;
  logic             rst;
  logic             en;
  logic             x;
  logic             polarity;
  logic             y;
  logic             y_pulse;
  logic [CNT_W-1:0] run_cnt;
  logic [1:0]       state;
`ifdef RUN_HIT_COUNT_EN
  logic [HIT_W-1:0] hit_cnt;
`endif

  run_length_detector #(.RUN_LEN(RUN_LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .x        (x),
    .polarity (polarity),
    .y        (y),
    .y_pulse  (y_pulse),
    .run_cnt  (run_cnt),
    .state    (state)
`ifdef RUN_HIT_COUNT_EN
    , .hit_cnt (hit_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;

  // Model state: length of the current run of matches, unbounded.
  int   m_len   = 0;
  logic m_pulse = 1'b0;
  logic m_pol_q = 1'b0;
  int   m_hit   = 0;

  function automatic logic [W-1:0] pack_exp();
    logic [1:0]       st;
    logic [CNT_W-1:0] c;
    logic             yy;
    if (m_len == 0)            st = 2'b00;
    else if (m_len >= RUN_LEN) st = 2'b10;
    else                       st = 2'b01;
    c  = (m_len >= RUN_LEN) ? CNT_W'(RUN_LEN) : CNT_W'(m_len);
    yy = (m_len >= RUN_LEN);
`ifdef RUN_HIT_COUNT_EN
    return {st, c, yy, m_pulse, HIT_W'(m_hit)};
`else
    return {st, c, yy, m_pulse};
`endif
  endfunction

  function automatic logic [W-1:0] pack_dut();
`ifdef RUN_HIT_COUNT_EN
    return {state, run_cnt, y, y_pulse, hit_cnt};
`else
    return {state, run_cnt, y, y_pulse};
`endif
  endfunction

  // Monitor: the DUT presents a fresh registered result every cycle.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = pack_dut();
      n_pop++;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL out_check cycle %0d: got {state,run_cnt,y,y_pulse[,hit]}=%h required %h",
                 n_pop, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic e_i, input logic x_i, input logic p_i);
    en = e_i; x = x_i; polarity = p_i;
    @(posedge clk);
`ifdef RUN_HIT_COUNT_EN
    if (m_pulse && m_hit < (1 << HIT_W) - 1) m_hit++;
`endif
    if (p_i != m_pol_q) begin
      m_len = 0; m_pulse = 1'b0;
    end else if (e_i) begin
      if (x_i ^ p_i) begin
        if (m_len < 100000) m_len++;
        m_pulse = (m_len == RUN_LEN);
      end else begin
        m_len = 0; m_pulse = 1'b0;
      end
    end else begin
      m_pulse = 1'b0;
    end
    m_pol_q = p_i;
    exp_q.push_back(pack_exp());
    @(negedge clk);
  endtask

  task automatic check_now(input string name, input logic [W-1:0] req);
    n_checks++;
    if (pack_dut() !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, pack_dut(), req);
    end
  endtask

  task automatic model_reset();
    m_len = 0; m_pulse = 1'b0; m_hit = 0; m_pol_q = polarity;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; x = 1'b0; polarity = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_now("reset_state", pack_exp());
    @(negedge clk);
    rst = 1'b0;

    // Run of five ones: detect on the third, pulse once.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Broken runs never detect.
    begin
      logic [5:0] pat;
      pat = 6'b110110;
      for (int i = 5; i >= 0; i--) step(1'b1, pat[i], 1'b0);
    end

    // Enable gating with x held high.
    for (int i = 0; i < 5; i++) step((i % 2) == 0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Runs of zeros, then a polarity flip forces IDLE.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle while in DETECT.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_now("async_reset_in_detect", pack_exp());
    @(negedge clk);
    rst = 1'b0;

`ifdef RUN_HIT_COUNT_EN
    // Enough detections to reach saturation of the hit counter.
    for (int r = 0; r < (1 << HIT_W) + 4; r++) begin
      for (int i = 0; i < RUN_LEN; i++) step(1'b1, 1'b1, polarity);
      step(1'b1, ~polarity, polarity);
    end
`endif

    // Randomized traffic biased toward long runs.
    for (int i = 0; i < 2500; i++) begin
      logic e_r, x_r, p_r;
      e_r = ($urandom_range(0, 9) != 0);
      x_r = ($urandom_range(0, 3) != 0) ? ~polarity : polarity;
      p_r = ($urandom_range(0, 39) == 0) ? ~polarity : polarity;
      step(e_r, x_r, p_r);
    end

    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
